// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared camera sync types: tracker FSM states and Bayer phase masks
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRAME  = 2'd1,
    LINE   = 2'd2,
    VBLANK = 2'd3
  } state_t;

  localparam logic [1:0] BAYER_RGGB = 2'b00;
  localparam logic [1:0] BAYER_GRBG = 2'b01;
  localparam logic [1:0] BAYER_GBRG = 2'b10;
  localparam logic [1:0] BAYER_BGGR = 2'b11;

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - clear-on-reset shift register aligning sync/coordinate fields to pixel data
module sync_delay_line #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/bayer_sync_tracker.sv
// rtl/bayer_sync_tracker.sv - decodes DVP vsync/href into pixel coordinates, Bayer phase and per-frame size
module bayer_sync_tracker
  import cam_pkg::*;
#(
  parameter int   X_WIDTH   = 12,
  parameter int   Y_WIDTH   = 12,
  parameter int   DELAY     = 5,
  parameter logic VSYNC_POL = 1'b1,
  parameter logic HSYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vsync,
  input  logic               in_hsync,
  input  logic [1:0]         pattern,
  output logic [1:0]         mode,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_eol,
  output logic [X_WIDTH-1:0] x_pos,
  output logic [Y_WIDTH-1:0] y_pos,
  output logic [X_WIDTH-1:0] frame_width,
  output logic [Y_WIDTH-1:0] frame_height,
  output logic               meas_valid,
  output logic               width_err
);

  localparam int PW = 5 + X_WIDTH + Y_WIDTH;

  function automatic logic [X_WIDTH-1:0] inc_x(input logic [X_WIDTH-1:0] a);
    return (&a) ? a : a + X_WIDTH'(1);
  endfunction

  function automatic logic [Y_WIDTH-1:0] inc_y(input logic [Y_WIDTH-1:0] a);
    return (&a) ? a : a + Y_WIDTH'(1);
  endfunction

  logic v, h, v_d, h_d, v_q, h_q;
  logic v_rise, v_fall, h_rise, h_fall;

  assign v = (in_vsync == VSYNC_POL);
  assign h = (in_hsync == HSYNC_POL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_d <= 1'b0;
      h_d <= 1'b0;
      v_q <= 1'b0;
      h_q <= 1'b0;
    end else begin
      v_d <= v;
      h_d <= h;
      v_q <= v_d;
      h_q <= h_d;
    end
  end

  assign v_rise = v_d & ~v_q;
  assign v_fall = ~v_d & v_q;
  assign h_rise = h_d & ~h_q;
  assign h_fall = ~h_d & h_q;

  state_t state, state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (v_rise) state_n = FRAME;
      FRAME:   if (v_fall) state_n = VBLANK;
               else if (h_rise) state_n = LINE;
      LINE:    if (v_fall) state_n = VBLANK;
               else if (h_fall) state_n = FRAME;
      VBLANK:  if (v_rise) state_n = h_rise ? LINE : FRAME;
      default: state_n = IDLE;
    endcase
  end

  logic               pix, line_close, frame_close, len_diff;
  logic               frame_ok, mismatch;
  logic [X_WIDTH-1:0] x, x_cur, line_len, ref_len, last_len;
  logic [Y_WIDTH-1:0] y, y_close;
  logic [1:0]         mode_c;
  logic               vs_c, eol_c;

  assign pix         = (state_n == LINE);
  assign line_close  = (state == LINE) && (h_fall || v_fall);
  assign frame_close = ((state == FRAME) || (state == LINE)) && v_fall;
  assign x_cur       = (state != LINE) ? '0 : inc_x(x);
  assign line_len    = inc_x(x);
  assign y_close     = inc_y(y);
  assign len_diff    = line_close && (y != '0) && (line_len != ref_len);

  // Raw v/h are one cycle ahead of v_d/h_d, so the last pixel is known on its own cycle.
  assign eol_c  = pix & ~(v & h);
  assign vs_c   = v_rise & (state == VBLANK);
  assign mode_c = pix ? {y[0] ^ pattern[1], x_cur[0] ^ pattern[0]} : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      ref_len  <= '0;
      last_len <= '0;
      mismatch <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      if (pix) x <= x_cur;
      if (v_rise) begin
        y        <= '0;
        ref_len  <= '0;
        last_len <= '0;
        mismatch <= 1'b0;
        frame_ok <= (state == VBLANK);
      end else if (line_close) begin
        y        <= y_close;
        last_len <= line_len;
        if (y == '0) ref_len <= line_len;
        if (len_diff) mismatch <= 1'b1;
      end
    end
  end

  // Frame results are captured on close, then published together with meas_valid.
  logic               cap_vld, cap_e;
  logic [X_WIDTH-1:0] cap_w;
  logic [Y_WIDTH-1:0] cap_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld      <= 1'b0;
      cap_w        <= '0;
      cap_h        <= '0;
      cap_e        <= 1'b0;
      meas_valid   <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      width_err    <= 1'b0;
    end else begin
      cap_vld    <= frame_close & frame_ok;
      meas_valid <= cap_vld;
      if (frame_close) begin
        cap_w <= line_close ? line_len : last_len;
        cap_h <= line_close ? y_close : y;
        cap_e <= mismatch | len_diff;
      end
      if (cap_vld) begin
        frame_width  <= cap_w;
        frame_height <= cap_h;
        width_err    <= cap_e;
      end
    end
  end

  logic [PW-1:0] dec_q, dly_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_q <= '0;
    else     dec_q <= {mode_c, pix, vs_c, eol_c,
                       pix ? x_cur : {X_WIDTH{1'b0}},
                       pix ? y : {Y_WIDTH{1'b0}}};
  end

  sync_delay_line #(
    .DEPTH(DELAY),
    .WIDTH(PW)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .din (dec_q),
    .dout(dly_out)
  );

  assign {mode, out_hsync, out_vsync, out_eol, x_pos, y_pos} = dly_out;

endmodule

// File: tb/tb_bayer_sync_tracker.sv
// tb/tb_bayer_sync_tracker.sv - scoreboard bench for bayer_sync_tracker (DELAY=5 main, X_WIDTH=3 narrow)
module tb_bayer_sync_tracker;

  localparam int DELAY = 5;
  localparam int LAT   = DELAY + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vsync = 1'b0;
  logic        in_hsync = 1'b0;
  logic [1:0]  pattern = 2'b00;

  logic [1:0]  mode;
  logic        out_hsync, out_vsync, out_eol, meas_valid, width_err;
  logic [11:0] x_pos, y_pos, frame_width, frame_height;

  logic [1:0]  n_mode;
  logic        n_hsync, n_vsync, n_eol, n_meas_valid, n_width_err;
  logic [2:0]  n_x_pos, n_frame_width;
  logic [11:0] n_y_pos, n_frame_height;

  bayer_sync_tracker #(.X_WIDTH(12), .Y_WIDTH(12), .DELAY(DELAY)) dut (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_hsync(in_hsync), .pattern(pattern),
    .mode(mode), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_eol(out_eol),
    .x_pos(x_pos), .y_pos(y_pos), .frame_width(frame_width), .frame_height(frame_height),
    .meas_valid(meas_valid), .width_err(width_err)
  );

  bayer_sync_tracker #(.X_WIDTH(3), .Y_WIDTH(12), .DELAY(0)) dut_narrow (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_hsync(in_hsync), .pattern(pattern),
    .mode(n_mode), .out_hsync(n_hsync), .out_vsync(n_vsync), .out_eol(n_eol),
    .x_pos(n_x_pos), .y_pos(n_y_pos), .frame_width(n_frame_width), .frame_height(n_frame_height),
    .meas_valid(n_meas_valid), .width_err(n_width_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] mode;
    logic       eol;
    int         x;
    int         y;
    int         t;
  } pix_t;

  typedef struct {
    int   w;
    int   h;
    logic err;
    int   t;
  } meas_t;

  pix_t  q_pix[$];
  int    q_vs[$];
  meas_t q_meas[$];
  meas_t q_nmeas[$];
  int    q_nx[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output present with nothing expected (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    pix_t  p;
    meas_t m;
    int    nx;
    if (!rst) begin
      if (out_hsync) begin
        if (q_pix.size() == 0) unexpected("pixel");
        else begin
          p = q_pix.pop_front();
          chk("pix_cycle", cyc, p.t);
          chk("mode", mode, p.mode);
          chk("x_pos", x_pos, p.x);
          chk("y_pos", y_pos, p.y);
          chk("eol", out_eol, p.eol);
        end
      end else if (out_eol) unexpected("eol_without_hsync");
      if (out_vsync) begin
        if (q_vs.size() == 0) unexpected("vsync");
        else chk("vsync_cycle", cyc, q_vs.pop_front());
      end
      if (meas_valid) begin
        if (q_meas.size() == 0) unexpected("meas_valid");
        else begin
          m = q_meas.pop_front();
          chk("meas_cycle", cyc, m.t);
          chk("frame_width", frame_width, m.w);
          chk("frame_height", frame_height, m.h);
          chk("width_err", width_err, m.err);
        end
      end
      if (n_meas_valid) begin
        if (q_nmeas.size() == 0) unexpected("narrow_meas_valid");
        else begin
          m = q_nmeas.pop_front();
          chk("narrow_meas_cycle", cyc, m.t);
          chk("narrow_frame_width", n_frame_width, m.w);
          chk("narrow_frame_height", n_frame_height, m.h);
          chk("narrow_width_err", n_width_err, m.err);
        end
      end
      if (n_eol) begin
        if (q_nx.size() == 0) unexpected("narrow_eol");
        else begin
          nx = q_nx.pop_front();
          chk("narrow_x_at_eol", n_x_pos, nx);
        end
      end
    end
  end

  task automatic step(input logic v, input logic h);
    @(posedge clk);
    #1;
    in_vsync = v;
    in_hsync = h;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_hsync"}, out_hsync, 0);
    chk({tag, "_vsync"}, out_vsync, 0);
    chk({tag, "_eol"}, out_eol, 0);
    chk({tag, "_x"}, x_pos, 0);
    chk({tag, "_y"}, y_pos, 0);
    chk({tag, "_fw"}, frame_width, 0);
    chk({tag, "_fh"}, frame_height, 0);
    chk({tag, "_mv"}, meas_valid, 0);
    chk({tag, "_werr"}, width_err, 0);
  endtask

  // One frame: 2 blank cycles after v rise, lines separated by 2 idle cycles, v falls after.
  task automatic frame(input int nl, input int l0, input int l1, input int l2,
                       input logic [1:0] pat, input bit measured, input bit vlast);
    int    lens[3];
    pix_t  p;
    meas_t m, mn;
    lens = '{l0, l1, l2};
    pattern = pat;
    step(1'b1, 1'b0);
    if (measured) q_vs.push_back(cyc + LAT);
    step(1'b1, 1'b0);
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < lens[l]; i++) begin
        step(1'b1, 1'b1);
        p.t    = cyc + LAT;
        p.x    = i;
        p.y    = l;
        p.eol  = (i == lens[l] - 1);
        p.mode = {l[0], i[0]} ^ pat;
        q_pix.push_back(p);
        if (p.eol) q_nx.push_back((i > 7) ? 7 : i);
      end
      if (!(vlast && l == nl - 1)) begin
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
      end
    end
    step(1'b0, 1'b0);
    m.t = cyc + 3;  m.h = nl;  m.w = (nl > 0) ? lens[nl-1] : 0;  m.err = 1'b0;
    mn = m;
    mn.w = (m.w > 7) ? 7 : m.w;
    for (int l = 1; l < nl; l++) begin
      if (lens[l] != lens[0]) m.err = 1'b1;
      if (((lens[l] > 7) ? 7 : lens[l]) != ((lens[0] > 7) ? 7 : lens[0])) mn.err = 1'b1;
    end
    if (measured) begin
      q_meas.push_back(m);
      q_nmeas.push_back(mn);
    end
    repeat (4) step(1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs_zero("reset");
    repeat (2) step(1'b0, 1'b0);

    frame(0, 0, 0, 0, 2'b00, 1'b0, 1'b0);   // leaves IDLE: discarded
    frame(3, 4, 4, 4, 2'b00, 1'b1, 1'b0);
    frame(3, 4, 4, 4, 2'b11, 1'b1, 1'b0);
    frame(3, 4, 5, 4, 2'b00, 1'b1, 1'b0);
    frame(3, 4, 4, 4, 2'b00, 1'b1, 1'b0);
    frame(2, 10, 10, 0, 2'b01, 1'b1, 1'b0);
    frame(2, 4, 4, 0, 2'b10, 1'b1, 1'b1);   // v and h drop together after the last pixel
    frame(0, 0, 0, 0, 2'b00, 1'b1, 1'b0);

    // Reset three pixels into the first line of a frame.
    pattern = 2'b00;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midreset");
    q_pix.delete();
    q_vs.delete();
    q_meas.delete();
    q_nmeas.delete();
    q_nx.delete();
    repeat (2) step(1'b1, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    in_hsync = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    frame(3, 4, 4, 4, 2'b00, 1'b1, 1'b0);

    repeat (20) step(1'b0, 1'b0);
    chk("pix_left", q_pix.size(), 0);
    chk("vsync_left", q_vs.size(), 0);
    chk("meas_left", q_meas.size(), 0);
    chk("narrow_meas_left", q_nmeas.size(), 0);
    chk("narrow_eol_left", q_nx.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
